// File: rtl/operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : logic_unit_pkg
// Description : Shared types and constants for the bitwise logic unit and
//               its upstream operand feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    // Operand width shared by the feeder and the logic unit
    localparam int c_BITS = 4;

    // One operand pair as buffered by the feeder FIFO
    typedef struct packed {
        logic [c_BITS-1:0] foo;
        logic [c_BITS-1:0] bar;
    } operand_pair_t;

endpackage : logic_unit_pkg
`default_nettype wire

// File: rtl/operand_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : op_fifo
// Description : Synchronous FIFO of operand pairs with push/pop/occupancy.
//               Occupancy count disambiguates full from empty, so pointers
//               are plain log2(DEPTH)-bit counters that wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module op_fifo
    import logic_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire operand_pair_t          i_wr_data,
    output operand_pair_t               o_rd_data,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    operand_pair_t   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Guard against overflow/underflow even if the caller misbehaves
    assign w_do_push = i_push && (r_count != c_FULL);
    assign w_do_pop  = i_pop  && (r_count != '0);

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; contents need no reset because count gates all reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : op_fifo
`default_nettype wire

// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : operand_feeder
// Description : Buffers operand pairs from a valid/ready source and issues at
//               most one pair per cycle as registered foo/bar/en to the
//               bitwise logic unit. res_valid marks the cycle the logic
//               unit's registered results reflect the last issued pair.
//               BITS must equal the package operand width.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_feeder
    import logic_unit_pkg::*;
#(
    parameter int BITS  = c_BITS,
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   in_valid,
    output logic                        in_ready,
    input  wire logic [BITS-1:0]        in_foo,
    input  wire logic [BITS-1:0]        in_bar,
    input  wire logic                   hold,
    output logic [BITS-1:0]             foo,
    output logic [BITS-1:0]             bar,
    output logic                        en,
    output logic                        res_valid,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    operand_pair_t   w_wr_data;
    operand_pair_t   w_head;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count;

    // Readiness depends only on registered occupancy, never on in_valid
    assign in_ready  = (w_count != c_FULL);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = !hold && (w_count != '0);
    assign count     = w_count;

    assign w_wr_data.foo = in_foo;
    assign w_wr_data.bar = in_bar;

    op_fifo #(
        .DEPTH     (DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (w_wr_data),
        .o_rd_data (w_head),
        .o_count   (w_count)
    );

    // Issue register: present the head pair with en for one cycle per pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            foo <= '0;
            bar <= '0;
            en  <= 1'b0;
        end else if (w_pop) begin
            foo <= w_head.foo;
            bar <= w_head.bar;
            en  <= 1'b1;
        end else begin
            en  <= 1'b0;
        end
    end

    // Results are fresh one cycle after each issue, matching the unit's register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
        end else begin
            res_valid <= en;
        end
    end

endmodule : operand_feeder
`default_nettype wire

// File: tb/tb_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_feeder
// Description : Self-checking bench for operand_feeder (BITS=4, DEPTH=4).
//               A behavioural occupancy model and an expected-pair queue
//               track every accepted pair; a negedge monitor compares the
//               issue stream, and directed steps cover reset and boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_feeder;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic       hold     = 1'b0;
    logic [3:0] in_foo   = '0;
    logic [3:0] in_bar   = '0;
    wire        in_ready;
    wire        en;
    wire        res_valid;
    wire  [3:0] foo;
    wire  [3:0] bar;
    wire  [2:0] count;

    int   errors   = 0;
    int   checks   = 0;
    int   n_issued = 0;
    bit   mon_on   = 1'b0;

    // Expected pairs in acceptance order, and a reference occupancy model
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    int         m_cnt = 0;
    logic       m_en  = 1'b0;
    logic       m_rv  = 1'b0;

    // Reference logic unit driven by the feeder's issue outputs
    logic [3:0] lu_and, lu_or, lu_xor, lu_nand;

    operand_feeder #(
        .BITS      (4),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_foo    (in_foo),
        .in_bar    (in_bar),
        .hold      (hold),
        .foo       (foo),
        .bar       (bar),
        .en        (en),
        .res_valid (res_valid),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Occupancy model: accept when not full, issue when not held and not empty
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_en  <= 1'b0;
            m_rv  <= 1'b0;
            sb.delete();
        end else begin
            if (in_valid && (m_cnt < 4)) sb.push_back({in_foo, in_bar});
            m_rv  <= m_en;
            m_en  <= !hold && (m_cnt > 0);
            m_cnt <= m_cnt + ((in_valid && (m_cnt < 4)) ? 1 : 0)
                           - ((!hold && (m_cnt > 0)) ? 1 : 0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_and  <= '0;
            lu_or   <= '0;
            lu_xor  <= '0;
            lu_nand <= '0;
        end else if (en) begin
            lu_and  <= foo & bar;
            lu_or   <= foo | bar;
            lu_xor  <= foo ^ bar;
            lu_nand <= ~(foo & bar);
        end
    end

    // Monitor: compare control outputs each cycle and pop the scoreboard per issue
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            chk("en", en, m_en);
            chk("res_valid", res_valid, m_rv);
            chk("count", count, m_cnt);
            chk("in_ready", in_ready, (m_cnt < 4));
            chk("count_max", (count <= 3'd4), 1);
            if (en === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("issue_data", {foo, bar}, mon_exp);
                end
                n_issued++;
            end
        end
    end

    initial begin
        int base;
        int idx;
        bit acc;

        // 1: reset asserted mid-clock takes effect immediately
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_en", en, 0);
        chk("rst_foo", foo, 0);
        chk("rst_bar", bar, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        mon_on = 1'b1;

        // 2: single pair, latency and logic-unit results
        in_foo = 4'hC; in_bar = 4'hA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_en_n", en, 0);
        tick();
        chk("t2_en", en, 1);
        chk("t2_foo", foo, 4'hC);
        chk("t2_bar", bar, 4'hA);
        tick();
        chk("t2_res_valid", res_valid, 1);
        chk("t2_and", lu_and, 4'h8);
        chk("t2_or", lu_or, 4'hE);
        chk("t2_xor", lu_xor, 4'h6);
        chk("t2_nand", lu_nand, 4'h7);
        tick();

        // 3: fill under hold, fifth pair waits, then drain in order
        base = n_issued;
        hold = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_foo = 4'(i); in_bar = ~4'(i);
            tick();
        end
        chk("t3_count_full", count, 4);
        chk("t3_in_ready", in_ready, 0);
        hold = 1'b0;
        tick();
        chk("t3_no_accept_when_full", count, 3);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("t3_issued", n_issued - base, 5);
        chk("t3_drained", count, 0);

        // 4: simultaneous push and pop at count=2
        hold = 1'b1; in_valid = 1'b1;
        in_foo = 4'h1; in_bar = 4'h2; tick();
        in_foo = 4'h3; in_bar = 4'h4; tick();
        chk("t4_count2", count, 2);
        hold = 1'b0;
        in_foo = 4'h5; in_bar = 4'h6; tick();
        chk("t4_count_same", count, 2);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t4_drained", count, 0);

        // 5: reset while busy clears everything and leaves nothing to issue
        hold = 1'b1; in_valid = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            in_foo = 4'(i); in_bar = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0; hold = 1'b0;
        tick();
        chk("t5_en_pre", en, 1);
        chk("t5_count_pre", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_en", en, 0);
        chk("t5_foo", foo, 0);
        chk("t5_bar", bar, 0);
        chk("t5_res_valid", res_valid, 0);
        chk("t5_count", count, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_stale_en", en, 0);
        end

        // 6: continuous offers with hold toggling every cycle
        base = n_issued;
        idx = 0;
        for (int c = 0; c < 200 && (n_issued - base) < 16; c++) begin
            hold     = c[0];
            in_valid = (idx < 16);
            in_foo   = idx[3:0];
            in_bar   = 4'(idx * 3 + 1);
            acc      = in_valid && (m_cnt < 4);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; hold = 1'b0;
        tick();
        chk("t6_pulses", n_issued - base, 16);
        chk("t6_accepted", idx, 16);
        chk("t6_sb_drained", sb.size(), 0);
        chk("t6_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_operand_feeder
`default_nettype wire
